// File: rtl/rf_pkg.sv
// Shared register-file definitions used by the move sequencer and the single-line mover.
package rf_pkg;

    localparam int unsigned RF_ADDR_W = 9;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StFin   = 2'd3
    } rf_mv_seq_state_t;

endpackage

// File: rtl/rf_mv_seq_if.sv
// Sequencer-to-mover link: one-line move request plus the mover's level done flag.
interface rf_mv_seq_if
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
);

    logic              mv_start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [7:0]        mv_line_num;
    logic              mv_done;

    modport master (
        output mv_start,
        output src_addr,
        output dst_addr,
        output mv_line_num,
        input  mv_done
    );

    modport slave (
        input  mv_start,
        input  src_addr,
        input  dst_addr,
        input  mv_line_num,
        output mv_done
    );

endinterface

// File: rtl/rf_mv_seq.sv
// Multi-line move sequencer: splits a block move into single-line mover requests,
// choosing the copy direction so overlapping ranges behave like memmove.
module rf_mv_seq
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [7:0]        cmd_lines,
    output logic              busy,
    output logic              done,
    output logic              err,
    rf_mv_seq_if.master       mv
);

    typedef logic [ADDR_W:0] ext_t;

    localparam ext_t Limit = {1'b1, {ADDR_W{1'b0}}};

    rf_mv_seq_state_t  state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [7:0]        rem_q, rem_d;
    logic              desc_q, desc_d;
    logic              err_q, err_d;

    ext_t src_end;
    ext_t dst_end;
    logic range_err;
    logic overlap_desc;

    // One-past-the-end addresses, one bit wider so the range check cannot wrap.
    assign src_end      = {1'b0, cmd_src} + ext_t'(cmd_lines);
    assign dst_end      = {1'b0, cmd_dst} + ext_t'(cmd_lines);
    assign range_err    = (src_end > Limit) || (dst_end > Limit);
    assign overlap_desc = (cmd_dst > cmd_src) && ({1'b0, cmd_dst} < src_end);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        desc_d  = desc_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    err_d  = range_err;
                    desc_d = overlap_desc;
                    rem_d  = cmd_lines;
                    if (range_err || (cmd_lines == 8'd0)) begin
                        state_d = StFin;
                    end else begin
                        state_d = StIssue;
                        if (overlap_desc) begin
                            src_d = ADDR_W'(src_end - ext_t'(1));
                            dst_d = ADDR_W'(dst_end - ext_t'(1));
                        end else begin
                            src_d = cmd_src;
                            dst_d = cmd_dst;
                        end
                    end
                end
            end
            StIssue: begin
                state_d = StWait;
            end
            StWait: begin
                if (mv.mv_done) begin
                    if (rem_q == 8'd1) begin
                        state_d = StFin;
                    end else begin
                        state_d = StIssue;
                        rem_d   = rem_q - 8'd1;
                        if (desc_q) begin
                            src_d = src_q - ADDR_W'(1);
                            dst_d = dst_q - ADDR_W'(1);
                        end else begin
                            src_d = src_q + ADDR_W'(1);
                            dst_d = dst_q + ADDR_W'(1);
                        end
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            desc_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            desc_q  <= desc_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready      = (state_q == StIdle);
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StFin);
    assign err            = (state_q == StFin) && err_q;
    assign mv.mv_start    = (state_q == StIssue);
    assign mv.src_addr    = src_q;
    assign mv.dst_addr    = dst_q;
    assign mv.mv_line_num = 8'd1;

endmodule

// File: tb/tb_rf_mv_seq.sv
// Directed bench for rf_mv_seq with a 3-cycle-latency mover model.
module tb_rf_mv_seq;

    localparam int unsigned AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_src = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic [7:0]    cmd_lines = '0;
    logic          busy;
    logic          done;
    logic          err;

    rf_mv_seq_if #(.ADDR_W(AW)) mv_if ();

    rf_mv_seq #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_lines (cmd_lines),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mv        (mv_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Mover model: not reset by rst, so an in-flight line still raises mv_done late.
    logic       mdone = 1'b0;
    logic [1:0] mcnt = 2'd0;
    assign mv_if.mv_done = mdone;
    always @(posedge clk) begin
        if (mv_if.mv_start) begin
            mdone <= 1'b0;
            mcnt  <= 2'd2;
        end else if (mcnt != 2'd0) begin
            mcnt <= mcnt - 2'd1;
            if (mcnt == 2'd1) mdone <= 1'b1;
        end
    end

    logic [AW-1:0] q_src[$];
    logic [AW-1:0] q_dst[$];
    int            q_cyc[$];
    always @(negedge clk) begin
        if (mv_if.mv_start) begin
            q_src.push_back(mv_if.src_addr);
            q_dst.push_back(mv_if.dst_addr);
            q_cyc.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_src.delete();
        q_dst.delete();
        q_cyc.delete();
    endtask

    task automatic wait_done(output int dcyc, output logic derr);
        int n;
        n = 0;
        dcyc = -1;
        derr = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done) begin
            dcyc = cyc;
            derr = err;
        end else begin
            check_val("done_timeout", 0, 1);
        end
    endtask

    task automatic run_cmd(input int src, input int dst, input int lines,
                           output int t_acc, output int dcyc, output logic derr);
        @(negedge clk);
        cmd_src   = AW'(src);
        cmd_dst   = AW'(dst);
        cmd_lines = 8'(lines);
        cmd_valid = 1'b1;
        check_val("cmd_ready_idle", int'(cmd_ready), 1);
        t_acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_val("busy_after_accept", int'(busy || done), 1);
        wait_done(dcyc, derr);
    endtask

    task automatic check_starts(input string tag, input int n, input int src0, input int dst0,
                                input int step, input int t_acc);
        int m;
        check_val({tag, "_n_starts"}, q_src.size(), n);
        m = (q_src.size() < n) ? q_src.size() : n;
        for (int i = 0; i < m; i++) begin
            check_val($sformatf("%s_src%0d", tag, i), int'(q_src[i]), src0 + step * i);
            check_val($sformatf("%s_dst%0d", tag, i), int'(q_dst[i]), dst0 + step * i);
            check_val($sformatf("%s_cyc%0d", tag, i), q_cyc[i] - t_acc, 1 + 4 * i);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_err"}, int'(err), 0);
        check_val({tag, "_mv_start"}, int'(mv_if.mv_start), 0);
        check_val({tag, "_src_addr"}, int'(mv_if.src_addr), 0);
        check_val({tag, "_dst_addr"}, int'(mv_if.dst_addr), 0);
        check_val({tag, "_line_num"}, int'(mv_if.mv_line_num), 1);
    endtask

    initial begin
        int   t, dc, tb2, nst, n;
        logic de;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        // Ascending, no overlap
        clear_q();
        run_cmd(10, 20, 3, t, dc, de);
        check_starts("asc", 3, 10, 20, 1, t);
        check_val("asc_done_cyc", dc - t, 13);
        check_val("asc_err", int'(de), 0);
        @(negedge clk);
        check_val("asc_ready_after", int'(cmd_ready), 1);

        // Overlap with dst above src: copy top-down
        clear_q();
        run_cmd(10, 12, 4, t, dc, de);
        check_starts("desc", 4, 13, 15, -1, t);
        check_val("desc_done_cyc", dc - t, 17);

        // Overlap with dst below src: copy bottom-up
        clear_q();
        run_cmd(12, 10, 4, t, dc, de);
        check_starts("ovl_asc", 4, 12, 10, 1, t);
        check_val("ovl_asc_done_cyc", dc - t, 17);

        // Range error just past the end
        clear_q();
        run_cmd(510, 0, 3, t, dc, de);
        check_val("rerr_done_cyc", dc - t, 1);
        check_val("rerr_err", int'(de), 1);
        check_val("rerr_n_starts", q_src.size(), 0);
        @(negedge clk);
        check_val("rerr_ready_after", int'(cmd_ready), 1);

        // Boundary: last line is 511
        clear_q();
        run_cmd(509, 0, 3, t, dc, de);
        check_starts("bound", 3, 509, 0, 1, t);
        check_val("bound_err", int'(de), 0);

        // Zero length
        clear_q();
        run_cmd(5, 6, 0, t, dc, de);
        check_val("zero_done_cyc", dc - t, 1);
        check_val("zero_err", int'(de), 0);
        check_val("zero_n_starts", q_src.size(), 0);

        // Command held while busy waits until the sequencer is idle again
        clear_q();
        @(negedge clk);
        cmd_src = AW'(30); cmd_dst = AW'(40); cmd_lines = 8'd2; cmd_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        cmd_src = AW'(50); cmd_dst = AW'(60); cmd_lines = 8'd1;
        check_val("held_ready_busy", int'(cmd_ready), 0);
        check_val("held_busy", int'(busy), 1);
        wait_done(dc, de);
        check_val("held_a_done_cyc", dc - t, 9);
        @(negedge clk);
        check_val("held_ready_idle", int'(cmd_ready), 1);
        tb2 = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(dc, de);
        check_val("held_b_done_cyc", dc - tb2, 5);
        check_val("held_n_starts", q_src.size(), 3);
        if (q_src.size() == 3) begin
            check_val("held_a_src1", int'(q_src[1]), 31);
            check_val("held_a_dst1", int'(q_dst[1]), 41);
            check_val("held_b_src", int'(q_src[2]), 50);
            check_val("held_b_dst", int'(q_dst[2]), 60);
            check_val("held_b_cyc", q_cyc[2] - tb2, 1);
        end

        // Reset in the middle of a 5-line command
        clear_q();
        @(negedge clk);
        cmd_src = AW'(100); cmd_dst = AW'(200); cmd_lines = 8'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        nst = 0;
        n = 0;
        while (nst < 2 && n < 100) begin
            if (mv_if.mv_start) nst++;
            if (nst < 2) begin
                @(negedge clk);
                n++;
            end
        end
        check_val("rstmid_saw_two", nst, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("rstmid");
        repeat (12) @(negedge clk);
        check_val("rstmid_n_starts", q_src.size(), 2);
        check_val("rstmid_idle", int'(cmd_ready), 1);

        clear_q();
        run_cmd(7, 8, 1, t, dc, de);
        check_starts("post_rst", 1, 7, 8, 1, t);
        check_val("post_rst_done_cyc", dc - t, 5);
        check_val("post_rst_err", int'(de), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_mv_seq.md
# rf_mv_seq

Multi-line move sequencer for the register file. Accepts one block-move command (source line, destination line, line count), splits it into single-line moves, and drives the master-side interface of the single-line mover (`mv_start`/`src_addr`/`dst_addr`/`mv_line_num`/`mv_done`). It sits between the NPU controller and the mover and provides memmove semantics: overlapping ranges are copied in the order that never reads a line it has already overwritten.

## Interface
- `ADDR_W`, default 9: register-file line address width; must match the mover.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  sequencer can accept a command (IDLE only).
- `cmd_src`  in  ADDR_W  first source line.
- `cmd_dst`  in  ADDR_W  first destination line.
- `cmd_lines`  in  8  line count, 0..255.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse at end of each accepted command.
- `err`  out  1  qualified by `done`; 1 means range error, no line moved.
- `mv_start`  out  1  one-cycle start pulse to mover.
- `src_addr`, `dst_addr`  out  ADDR_W  line addresses for the current move, stable from the `mv_start` cycle until the next one.
- `mv_line_num`  out  8  constant 1.
- `mv_done`  in  1  mover done flag; level, cleared by the mover on the clock edge that samples `mv_start`.

## Operation
- States: IDLE, ISSUE, WAIT, FIN.
- IDLE: `cmd_ready`=1. On `cmd_valid`: latch the command.
  - Range check at ADDR_W+1 bits: error if `cmd_src+cmd_lines` > 2^ADDR_W or `cmd_dst+cmd_lines` > 2^ADDR_W.
  - Error or `cmd_lines`=0: go to FIN.
  - Otherwise go to ISSUE.
- Direction:
  - Descending if `cmd_dst > cmd_src` and `cmd_dst < cmd_src+cmd_lines`. First addresses are `cmd_src+cmd_lines-1` and `cmd_dst+cmd_lines-1`; both decrement after each line.
  - Ascending otherwise, including `src==dst`. First addresses are `cmd_src` and `cmd_dst`; both increment.
- ISSUE: `mv_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: hold until `mv_done`=1.
  - Remaining count equals 1: go to FIN.
  - Otherwise: decrement remaining, step both addresses, go to ISSUE.
- FIN: `done`=1 and `err` valid for this cycle, then go to IDLE.
- `mv_done` is ignored outside WAIT, including a stale high level while IDLE.
- `cmd_valid` is ignored while busy; the command is not latched.
- Address arithmetic never wraps on an accepted command; the range check guarantees this.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `mv_start`=0, `src_addr`=`dst_addr`=0, `mv_line_num`=1.
- A command accepted at edge t produces the first `mv_start` in cycle t+1.
- Each next `mv_start` comes 1 cycle after the cycle in which `mv_done` is seen high in WAIT.
- With a mover latency of 3 cycles (start at s, `mv_done` high at s+3), the period is 4 cycles per line.
- A move of N lines accepted at edge t: `done` in cycle t+4N+1, next `cmd_ready` in t+4N+2.
- Zero-length or error command: `done` in t+1, `cmd_ready` again in t+2, no `mv_start`.
- `rst` mid-command: returns to reset values on the next edge and issues no further `mv_start`. The late `mv_done` of an in-flight line is ignored. The sequencer does not abort the mover.

## Structure
- Shared package `rf_pkg`: `rf_mv_seq_state_t` enum (IDLE, ISSUE, WAIT, FIN) and the `RF_ADDR_W` constant, both shared with the mover.
- Single module with no sub-modules. Address up/down counters and the remaining-line counter are inline.

## Test plan
Bench uses a mover model with 3-cycle `mv_done` latency.
- Basic ascending: src=10, dst=20, lines=3 -> starts (10,20), (11,21), (12,22); periods of 4 cycles; `done`=1 and `err`=0 at t+13.
- Overlap with dst > src: src=10, dst=12, lines=4 -> descending starts (13,15), (12,14), (11,13), (10,12).
- Overlap with dst < src: src=12, dst=10, lines=4 -> ascending starts (12,10) … (15,13).
- Range error (ADDR_W=9): src=510, dst=0, lines=3 -> no `mv_start`; `done`=1 and `err`=1 at t+1. Boundary check: src=509, lines=3 -> accepted, 3 moves.
- Zero length: lines=0 -> `done`=1 and `err`=0 at t+1, no `mv_start`. A command offered while busy is not accepted: `cmd_ready`=0, and the bench verifies the held command is accepted after `done`.
- Reset mid-command: lines=5, `rst` asserted after the 2nd `mv_start` -> no further `mv_start`, all outputs at reset values; a following command with lines=1 completes normally.
